pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32: width of all PC, operand and immediate buses.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000: PC value loaded by reset.
REQ-003 Parameter TRAP_VECTOR, default 32'h0000_0100: PC value loaded on a misaligned-target trap.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 stall  input  1  hold PC in RUN state.
REQ-007 branch, take_branch, jump, jalr  input  1 each  control-flow qualifiers from decode/compare.
REQ-008 rs1_val, imm_i, imm_b, imm_j  input  XLEN each  JALR base and sign-extended immediates.
REQ-009 pc  output  XLEN  registered current PC.
REQ-010 pc_plus4  output  XLEN  combinational pc + 4, the link value.
REQ-011 pc_next  output  XLEN  combinational selected target, before alignment check.
REQ-012 pc_valid  output  1  registered; high only in RUN state.
REQ-013 misalign_trap  output  1  registered one-cycle pulse on a misaligned redirect.
REQ-014 mtval  output  XLEN  registered faulting target, held until the next trap.

Function
REQ-015 Target priority shall be: jalr -> (rs1_val + imm_i) & ~1; else jump -> pc + imm_j; else branch & take_branch -> pc + imm_b; else pc + 4.
REQ-016 All additions shall be modulo 2^XLEN and wrap silently, e.g. pc = FFFF_FFFC gives pc_plus4 = 0000_0000.
REQ-017 take_branch without branch shall be ignored.
REQ-018 FSM states shall be BOOT, RUN and TRAP.
REQ-019 BOOT: pc_valid = 0 and pc is held; BOOT shall go to RUN on the next edge unconditionally, with stall ignored.
REQ-020 RUN, stall = 1: pc, state, mtval are held and misalign_trap = 0; stall takes priority over all redirect and trap detection.
REQ-021 RUN, stall = 0, pc_next[1:0] == 0: pc <= pc_next; the state stays RUN.
REQ-022 RUN, stall = 0, pc_next[1:0] != 0 (only possible on a jalr, jump or taken-branch redirect): pc <= TRAP_VECTOR, mtval <= pc_next, misalign_trap <= 1, state <= TRAP.
REQ-023 TRAP: pc_valid = 0 and misalign_trap = 1 for exactly this cycle; TRAP shall go to RUN on the next edge with pc held at TRAP_VECTOR, and stall is ignored.
REQ-024 In every state pc_plus4 and pc_next shall reflect the current pc and inputs; consumers qualify them with pc_valid.
REQ-025 Latency: a redirect selected in cycle N shall appear on pc in cycle N+1; there is no bubble except BOOT and TRAP.

Reset
REQ-026 rst = 1 at a clock edge shall force: state = BOOT, pc = RESET_VECTOR, pc_valid = 0, misalign_trap = 0, mtval = 0.
REQ-027 rst shall take priority over stall and over every FSM transition, including a reset asserted mid-TRAP.
REQ-028 Outputs shall be undefined before the first rst edge; no asynchronous path exists.

Structure
REQ-029 FSM state encodings (BOOT = 2'd0, RUN = 2'd1, TRAP = 2'd2) and the default vectors shall live in the shared rv32i package/include, not locally.
REQ-030 Target selection (REQ-015) shall be one combinational sub-module, pc_target_sel, parametrised by XLEN; pc_gen holds the FSM and registers.

Verification
REQ-031 rst for 2 cycles, release -> pc = 0000_0000, pc_valid = 0 for one cycle, then RUN; next edge pc = 0000_0004.
REQ-032 pc = 0000_0200, branch = 1, take_branch = 1, imm_b = FFFF_FFF0, stall = 0 -> next pc = 0000_01F0, pc_plus4 before the edge = 0000_0204.
REQ-033 pc = 0000_0400, jalr = 1, jump = 1, rs1_val = 0000_1003, imm_i = 4 -> pc_next = 0000_1006; next state TRAP, pc = 0000_0100, mtval = 0000_1006, misalign_trap pulse of 1 cycle, then RUN at 0000_0100.
REQ-034 RUN at pc = 0000_0300, stall = 1 for 3 cycles with jump = 1, imm_j = 0000_0020 -> pc held at 0000_0300; first unstalled edge -> pc = 0000_0320.
REQ-035 pc = FFFF_FFFC, no redirect -> next pc = 0000_0000, no trap.
REQ-036 rst asserted during the TRAP cycle -> next edge state BOOT, pc = RESET_VECTOR, misalign_trap = 0, mtval = 0.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared definitions for the program-counter generator.
// Contents:
//   pc_state_e           - FSM state encoding (BOOT / RUN / TRAP)
//   DEFAULT_XLEN         - default datapath width
//   DEFAULT_RESET_VECTOR - PC loaded by reset
//   DEFAULT_TRAP_VECTOR  - PC loaded on a misaligned-target trap
//   is_misaligned()      - instruction-alignment check on the two LSBs
package pc_gen_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2
  } pc_state_e;

  localparam int          DEFAULT_XLEN         = 32;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

  // Instructions are 32-bit aligned; any set bit in [1:0] is a fault.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/pc_target_sel.sv
// Combinational next-PC target selection.
// Ports:
//   pc           in   current PC
//   branch       in   instruction is a conditional branch
//   take_branch  in   branch condition evaluated true (ignored without branch)
//   jump         in   JAL
//   jalr         in   JALR (highest priority)
//   rs1_val      in   JALR base register
//   imm_i/b/j    in   sign-extended immediates
//   pc_plus4     out  pc + 4 (link value)
//   pc_next      out  selected target, before alignment check
module pc_target_sel #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            branch,
  input  logic            take_branch,
  input  logic            jump,
  input  logic            jalr,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] imm_b,
  input  logic [XLEN-1:0] imm_j,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] pc_next
);

  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(32'd4);
  // JALR clears only bit 0 of the sum; bit 1 survives so it can still trap.
  localparam logic [XLEN-1:0] LSB_CLEAR = {{(XLEN-1){1'b1}}, 1'b0};

  logic [XLEN-1:0] jalr_sum_s;

  // Sequential link value; all additions wrap modulo 2^XLEN.
  always_comb begin
    pc_plus4   = pc + PC_STEP;
    jalr_sum_s = rs1_val + imm_i;
  end

  // Priority mux: jalr > jump > taken branch > fall-through.
  always_comb begin
    pc_next = pc_plus4;
    if (jalr) begin
      pc_next = jalr_sum_s & LSB_CLEAR;
    end else if (jump) begin
      pc_next = pc + imm_j;
    end else if (branch && take_branch) begin
      pc_next = pc + imm_b;
    end else begin
      pc_next = pc_plus4;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator with BOOT / RUN / TRAP sequencing.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   stall             hold the PC while in RUN
//   branch, take_branch, jump, jalr   control-flow qualifiers
//   rs1_val, imm_i, imm_b, imm_j      JALR base and immediates
//   pc                registered current PC
//   pc_plus4          combinational pc + 4
//   pc_next           combinational selected target
//   pc_valid          registered, high only in RUN
//   misalign_trap     registered one-cycle pulse (the TRAP cycle)
//   mtval             registered faulting target, held until the next trap
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN         = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch,
  input  logic            take_branch,
  input  logic            jump,
  input  logic            jalr,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] imm_b,
  input  logic [XLEN-1:0] imm_j,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] pc_next,
  output logic            pc_valid,
  output logic            misalign_trap,
  output logic [XLEN-1:0] mtval
);

  pc_state_e       state_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] mtval_r;
  logic            pc_valid_r;
  logic            misalign_trap_r;
  logic [XLEN-1:0] pc_next_s;
  logic [XLEN-1:0] pc_plus4_s;

  pc_target_sel #(.XLEN(XLEN)) u_target_sel (
    .pc          (pc_r),
    .branch      (branch),
    .take_branch (take_branch),
    .jump        (jump),
    .jalr        (jalr),
    .rs1_val     (rs1_val),
    .imm_i       (imm_i),
    .imm_b       (imm_b),
    .imm_j       (imm_j),
    .pc_plus4    (pc_plus4_s),
    .pc_next     (pc_next_s)
  );

  // FSM and all registered outputs. pc_valid / misalign_trap are computed
  // from the state being entered so they line up with that state's cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= ST_BOOT;
      pc_r            <= RESET_VECTOR;
      mtval_r         <= '0;
      pc_valid_r      <= 1'b0;
      misalign_trap_r <= 1'b0;
    end else begin
      case (state_r)
        ST_BOOT: begin
          state_r         <= ST_RUN;
          pc_valid_r      <= 1'b1;
          misalign_trap_r <= 1'b0;
        end
        ST_RUN: begin
          if (stall) begin
            // Stall masks both the redirect and the alignment check.
            pc_valid_r      <= 1'b1;
            misalign_trap_r <= 1'b0;
          end else if (is_misaligned(pc_next_s[1:0])) begin
            state_r         <= ST_TRAP;
            pc_r            <= TRAP_VECTOR;
            mtval_r         <= pc_next_s;
            pc_valid_r      <= 1'b0;
            misalign_trap_r <= 1'b1;
          end else begin
            pc_r            <= pc_next_s;
            pc_valid_r      <= 1'b1;
            misalign_trap_r <= 1'b0;
          end
        end
        ST_TRAP: begin
          // PC already sits at TRAP_VECTOR; resume fetching from there.
          state_r         <= ST_RUN;
          pc_valid_r      <= 1'b1;
          misalign_trap_r <= 1'b0;
        end
        default: begin
          state_r         <= ST_BOOT;
          pc_r            <= RESET_VECTOR;
          pc_valid_r      <= 1'b0;
          misalign_trap_r <= 1'b0;
        end
      endcase
    end
  end

  assign pc            = pc_r;
  assign pc_plus4      = pc_plus4_s;
  assign pc_next       = pc_next_s;
  assign pc_valid      = pc_valid_r;
  assign misalign_trap = misalign_trap_r;
  assign mtval         = mtval_r;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus a randomized run
// compared against a behavioural model of the PC sequencing rules.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst, stall, branch, take_branch, jump, jalr;
  logic [31:0] rs1_val, imm_i, imm_b, imm_j;
  logic [31:0] pc, pc_plus4, pc_next, mtval;
  logic        pc_valid, misalign_trap;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state.
  logic [31:0] m_pc, m_mtval;
  logic        m_valid, m_trap;

  pc_gen dut (
    .clk(clk), .rst(rst), .stall(stall), .branch(branch),
    .take_branch(take_branch), .jump(jump), .jalr(jalr),
    .rs1_val(rs1_val), .imm_i(imm_i), .imm_b(imm_b), .imm_j(imm_j),
    .pc(pc), .pc_plus4(pc_plus4), .pc_next(pc_next),
    .pc_valid(pc_valid), .misalign_trap(misalign_trap), .mtval(mtval)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_target();
    if (jalr)                      return (rs1_val + imm_i) & 32'hFFFF_FFFE;
    else if (jump)                 return m_pc + imm_j;
    else if (branch && take_branch) return m_pc + imm_b;
    else                           return m_pc + 32'd4;
  endfunction

  // Apply one clock edge to the model using the currently driven inputs.
  function automatic void model_edge();
    logic [31:0] tgt;
    if (rst) begin
      m_pc = 32'h0; m_valid = 1'b0; m_trap = 1'b0; m_mtval = 32'h0;
    end else if (!m_valid) begin
      // Boot or trap bubble: always resume fetching next cycle.
      m_valid = 1'b1; m_trap = 1'b0;
    end else if (stall) begin
      m_trap = 1'b0;
    end else begin
      tgt = exp_target();
      if (tgt % 32'd4 != 32'd0) begin
        m_mtval = tgt; m_pc = 32'h100; m_valid = 1'b0; m_trap = 1'b1;
      end else begin
        m_pc = tgt; m_trap = 1'b0;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    stall = 1'b0; branch = 1'b0; take_branch = 1'b0; jump = 1'b0; jalr = 1'b0;
    rs1_val = 32'h0; imm_i = 32'h0; imm_b = 32'h0; imm_j = 32'h0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick(); tick();
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    checks++; if (pc_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", pc_valid); end
    checks++; if (misalign_trap !== 1'b0) begin failures++; $display("FAIL reset_trap got=%b exp=0", misalign_trap); end
    checks++; if (mtval !== 32'h0) begin failures++; $display("FAIL reset_mtval got=%h exp=0", mtval); end
    rst = 1'b0;
    stall = 1'b1; // ignored in BOOT
    tick();
    checks++; if (pc_valid !== 1'b1 || pc !== 32'h0) begin failures++; $display("FAIL boot_to_run valid=%b pc=%h exp valid=1 pc=0", pc_valid, pc); end
    stall = 1'b0;
    tick();
    checks++; if (pc !== 32'h4) begin failures++; $display("FAIL first_step got=%h exp=%h", pc, 32'h4); end
  endtask

  task automatic test_branch();
    clear_inputs();
    jump = 1'b1; imm_j = 32'h200 - m_pc;
    tick();
    checks++; if (pc !== 32'h200) begin failures++; $display("FAIL jump_to_200 got=%h exp=%h", pc, 32'h200); end
    clear_inputs();
    branch = 1'b1; take_branch = 1'b1; imm_b = 32'hFFFF_FFF0;
    #1;
    checks++; if (pc_plus4 !== 32'h204) begin failures++; $display("FAIL branch_plus4 got=%h exp=%h", pc_plus4, 32'h204); end
    checks++; if (pc_next !== 32'h1F0) begin failures++; $display("FAIL branch_next got=%h exp=%h", pc_next, 32'h1F0); end
    tick();
    checks++; if (pc !== 32'h1F0) begin failures++; $display("FAIL branch_pc got=%h exp=%h", pc, 32'h1F0); end
    // take_branch alone must not redirect.
    clear_inputs();
    take_branch = 1'b1; imm_b = 32'h40;
    #1;
    checks++; if (pc_next !== 32'h1F4) begin failures++; $display("FAIL take_no_branch got=%h exp=%h", pc_next, 32'h1F4); end
    tick();
    checks++; if (pc !== 32'h1F4) begin failures++; $display("FAIL take_no_branch_pc got=%h exp=%h", pc, 32'h1F4); end
  endtask

  task automatic test_jalr_trap();
    clear_inputs();
    jump = 1'b1; imm_j = 32'h400 - m_pc;
    tick();
    checks++; if (pc !== 32'h400) begin failures++; $display("FAIL jump_to_400 got=%h exp=%h", pc, 32'h400); end
    jalr = 1'b1; jump = 1'b1; rs1_val = 32'h1003; imm_i = 32'h4;
    #1;
    checks++; if (pc_next !== 32'h1006) begin failures++; $display("FAIL jalr_next got=%h exp=%h", pc_next, 32'h1006); end
    tick();
    checks++; if (pc !== 32'h100 || misalign_trap !== 1'b1 || pc_valid !== 1'b0 || mtval !== 32'h1006) begin
      failures++; $display("FAIL trap_entry pc=%h trap=%b valid=%b mtval=%h exp 100/1/0/1006", pc, misalign_trap, pc_valid, mtval);
    end
    clear_inputs();
    stall = 1'b1; // ignored in TRAP
    tick();
    checks++; if (pc !== 32'h100 || misalign_trap !== 1'b0 || pc_valid !== 1'b1 || mtval !== 32'h1006) begin
      failures++; $display("FAIL trap_exit pc=%h trap=%b valid=%b mtval=%h exp 100/0/1/1006", pc, misalign_trap, pc_valid, mtval);
    end
    stall = 1'b0;
  endtask

  task automatic test_stall();
    clear_inputs();
    jump = 1'b1; imm_j = 32'h300 - m_pc;
    tick();
    checks++; if (pc !== 32'h300) begin failures++; $display("FAIL jump_to_300 got=%h exp=%h", pc, 32'h300); end
    stall = 1'b1; imm_j = 32'h20;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc !== 32'h300 || pc_valid !== 1'b1) begin failures++; $display("FAIL stall_hold[%0d] pc=%h valid=%b exp 300/1", i, pc, pc_valid); end
    end
    stall = 1'b0;
    tick();
    checks++; if (pc !== 32'h320) begin failures++; $display("FAIL stall_release got=%h exp=%h", pc, 32'h320); end
  endtask

  task automatic test_wrap();
    clear_inputs();
    jump = 1'b1; imm_j = 32'hFFFF_FFFC - m_pc;
    tick();
    checks++; if (pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL jump_to_top got=%h exp=%h", pc, 32'hFFFF_FFFC); end
    clear_inputs();
    #1;
    checks++; if (pc_plus4 !== 32'h0 || pc_next !== 32'h0) begin failures++; $display("FAIL wrap_comb plus4=%h next=%h exp 0/0", pc_plus4, pc_next); end
    tick();
    checks++; if (pc !== 32'h0 || misalign_trap !== 1'b0 || pc_valid !== 1'b1) begin failures++; $display("FAIL wrap_pc pc=%h trap=%b valid=%b exp 0/0/1", pc, misalign_trap, pc_valid); end
  endtask

  task automatic test_reset_in_trap();
    clear_inputs();
    jump = 1'b1; imm_j = 32'h2;
    tick();
    checks++; if (misalign_trap !== 1'b1 || mtval !== m_pc - m_pc + 32'h2 + 32'h0) begin
      failures++; $display("FAIL jump_trap trap=%b mtval=%h exp 1/00000002", misalign_trap, mtval);
    end
    clear_inputs();
    rst = 1'b1;
    tick();
    checks++; if (pc !== 32'h0 || misalign_trap !== 1'b0 || mtval !== 32'h0 || pc_valid !== 1'b0) begin
      failures++; $display("FAIL reset_in_trap pc=%h trap=%b mtval=%h valid=%b exp 0/0/0/0", pc, misalign_trap, mtval, pc_valid);
    end
    rst = 1'b0;
    tick();
    checks++; if (pc_valid !== 1'b1 || pc !== 32'h0) begin failures++; $display("FAIL reboot valid=%b pc=%h exp 1/0", pc_valid, pc); end
  endtask

  task automatic test_random();
    logic [31:0] align_mask;
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 59) == 0);
      stall       = ($urandom_range(0, 4) == 0);
      branch      = $urandom_range(0, 1);
      take_branch = $urandom_range(0, 1);
      jump        = ($urandom_range(0, 3) == 0);
      jalr        = ($urandom_range(0, 5) == 0);
      align_mask  = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC;
      rs1_val     = $urandom & align_mask;
      imm_i       = $urandom & align_mask;
      imm_b       = $urandom & align_mask;
      imm_j       = $urandom & align_mask;
      #1;
      checks++; if (pc_plus4 !== m_pc + 32'd4) begin failures++; $display("FAIL rand_plus4[%0d] got=%h exp=%h", i, pc_plus4, m_pc + 32'd4); end
      checks++; if (pc_next !== exp_target()) begin failures++; $display("FAIL rand_next[%0d] got=%h exp=%h", i, pc_next, exp_target()); end
      tick();
      checks++; if (pc !== m_pc) begin failures++; $display("FAIL rand_pc[%0d] got=%h exp=%h", i, pc, m_pc); end
      checks++; if (pc_valid !== m_valid || misalign_trap !== m_trap) begin
        failures++; $display("FAIL rand_flags[%0d] valid=%b trap=%b exp %b/%b", i, pc_valid, misalign_trap, m_valid, m_trap);
      end
      checks++; if (mtval !== m_mtval) begin failures++; $display("FAIL rand_mtval[%0d] got=%h exp=%h", i, mtval, m_mtval); end
    end
    rst = 1'b0;
  endtask

  initial begin
    m_pc = 32'h0; m_mtval = 32'h0; m_valid = 1'b0; m_trap = 1'b0;
    test_reset();
    test_branch();
    test_jalr_trap();
    test_stall();
    test_wrap();
    test_reset_in_trap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
